// File: rtl/io_pad_arbiter.sv
// Round-robin arbiter granting one pad function at a time, with forced idle turnaround after transmit use.
// Optional grant-hold timeout enabled by defining IO_PAD_ARBITER_TIMEOUT_EN.
module io_pad_arbiter #(
   parameter int RXCOUNT    = 2,
   parameter int TXCOUNT    = 2,
   parameter int TURNAROUND = 1,
   parameter int MAXHOLD    = 16,
   localparam int FUNCCOUNT = RXCOUNT + TXCOUNT,
   localparam int MUXWIDTH  = $clog2(FUNCCOUNT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [FUNCCOUNT-1:0] req,
   output logic [FUNCCOUNT-1:0] grant,
   output logic [MUXWIDTH-1:0]  func_select,
   output logic                 busy
);

   localparam int TCW = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;
   localparam logic [MUXWIDTH-1:0] FIRST_TX = MUXWIDTH'(RXCOUNT);
   localparam logic [MUXWIDTH-1:0] LAST_IDX = MUXWIDTH'(FUNCCOUNT - 1);

   if (FUNCCOUNT < 2) begin : g_bad_count
      $error("io_pad_arbiter: RXCOUNT+TXCOUNT must be at least 2");
   end
   if (MAXHOLD < 1) begin : g_bad_hold
      $error("io_pad_arbiter: MAXHOLD must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t                state_q, state_n;
   logic [FUNCCOUNT-1:0]  grant_q, grant_n;
   logic [MUXWIDTH-1:0]   sel_q, sel_n;
   logic [MUXWIDTH-1:0]   ptr_q, ptr_n;
   logic [TCW-1:0]        turn_q, turn_n;
   logic [MUXWIDTH-1:0]   pick;
   logic                  release_now;

`ifdef IO_PAD_ARBITER_TIMEOUT_EN
   localparam int HCW = $clog2(MAXHOLD + 1);
   logic [HCW-1:0] hold_q, hold_n;
`endif

   function automatic logic [MUXWIDTH-1:0] rr_index(input logic [MUXWIDTH-1:0] base,
                                                    input int unsigned offset);
      int unsigned s;
      s = int'(base) + offset;
      if (s >= FUNCCOUNT) s = s - FUNCCOUNT;
      return MUXWIDTH'(s);
   endfunction

   // First requester at or after the pointer, scanning with wrap-around.
   always_comb begin
      pick = '0;
      for (int unsigned k = FUNCCOUNT; k > 0; k--) begin
         if (req[rr_index(ptr_q, k - 1)]) pick = rr_index(ptr_q, k - 1);
      end
   end

   always_comb begin
      release_now = !req[sel_q];
`ifdef IO_PAD_ARBITER_TIMEOUT_EN
      if ((hold_q == HCW'(MAXHOLD)) && |(req & ~grant_q)) release_now = 1'b1;
`endif
   end

   always_comb begin
      state_n = state_q;
      grant_n = grant_q;
      sel_n   = sel_q;
      ptr_n   = ptr_q;
      turn_n  = turn_q;
`ifdef IO_PAD_ARBITER_TIMEOUT_EN
      hold_n  = hold_q;
`endif
      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_n       = '0;
               grant_n[pick] = 1'b1;
               sel_n         = pick;
               state_n       = GRANT;
`ifdef IO_PAD_ARBITER_TIMEOUT_EN
               hold_n        = HCW'(1);
`endif
            end
         end
         GRANT: begin
            if (release_now) begin
               grant_n = '0;
               sel_n   = '0;
               ptr_n   = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
               turn_n  = '0;
               state_n = ((sel_q >= FIRST_TX) && (TURNAROUND > 0)) ? TURN : IDLE;
            end
`ifdef IO_PAD_ARBITER_TIMEOUT_EN
            else if (hold_q != HCW'(MAXHOLD)) begin
               hold_n = hold_q + 1'b1;
            end
`endif
         end
         TURN: begin
            if (turn_q == TCW'(TURNAROUND - 1)) begin
               turn_n  = '0;
               state_n = IDLE;
            end else begin
               turn_n  = turn_q + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
            sel_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         turn_q  <= '0;
`ifdef IO_PAD_ARBITER_TIMEOUT_EN
         hold_q  <= '0;
`endif
      end else begin
         state_q <= state_n;
         grant_q <= grant_n;
         sel_q   <= sel_n;
         ptr_q   <= ptr_n;
         turn_q  <= turn_n;
`ifdef IO_PAD_ARBITER_TIMEOUT_EN
         hold_q  <= hold_n;
`endif
      end
   end

   assign grant       = grant_q;
   assign func_select = sel_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_io_pad_arbiter.sv
// Directed-vector bench for io_pad_arbiter (RXCOUNT=2, TXCOUNT=2, TURNAROUND=2, MAXHOLD=4).
module tb_io_pad_arbiter;

   localparam int RX = 2;
   localparam int TX = 2;
   localparam int TA = 2;
   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] func_select;
   logic       busy;

   always #5 clk = ~clk;

   io_pad_arbiter #(
      .RXCOUNT(RX), .TXCOUNT(TX), .TURNAROUND(TA), .MAXHOLD(MH)
   ) dut (
      .clk(clk), .rst(rst), .req(req),
      .grant(grant), .func_select(func_select), .busy(busy)
   );

   // One entry per cycle: expected outputs seen in that cycle, inputs driven during it.
   typedef struct {
      bit         r;
      logic [3:0] rq;
      logic [3:0] g;
      logic [1:0] s;
      logic       b;
   } vec_t;

   vec_t vecs[$];
   int   tests = 0;
   int   fails = 0;

   function automatic void add(bit r, logic [3:0] rq, logic [3:0] g, logic [1:0] s, logic b);
      vec_t v;
      v.r = r; v.rq = rq; v.g = g; v.s = s; v.b = b;
      vecs.push_back(v);
   endfunction

   task automatic chk(string name, int idx, logic [3:0] act, logic [3:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(string tag, int idx, logic [3:0] g, logic [1:0] s, logic b);
      chk({tag, "_grant"}, idx, grant, g);
      chk({tag, "_sel"},   idx, {2'b00, func_select}, {2'b00, s});
      chk({tag, "_busy"},  idx, {3'b000, busy}, {3'b000, b});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      // idle with no requests
      repeat (10) add(0, 4'b0000, 4'b0000, 2'd0, 0);
      // transmit grant, other bits ignored, turnaround, then receive grant
      add(0, 4'b0100, 4'b0000, 2'd0, 0);
      add(0, 4'b0100, 4'b0100, 2'd2, 1);
      add(0, 4'b1101, 4'b0100, 2'd2, 1);
      add(0, 4'b1101, 4'b0100, 2'd2, 1);
      add(0, 4'b0100, 4'b0100, 2'd2, 1);
      add(0, 4'b0000, 4'b0100, 2'd2, 1);
      add(0, 4'b0001, 4'b0000, 2'd0, 1);
      add(0, 4'b0001, 4'b0000, 2'd0, 1);
      add(0, 4'b0001, 4'b0000, 2'd0, 0);
      add(0, 4'b0000, 4'b0001, 2'd0, 1);
      add(0, 4'b0000, 4'b0000, 2'd0, 0);
      // receive release goes straight to idle
      add(0, 4'b0010, 4'b0000, 2'd0, 0);
      add(0, 4'b0010, 4'b0010, 2'd1, 1);
      add(0, 4'b0010, 4'b0010, 2'd1, 1);
      add(0, 4'b0001, 4'b0010, 2'd1, 1);
      add(0, 4'b0001, 4'b0000, 2'd0, 0);
      add(0, 4'b0000, 4'b0001, 2'd0, 1);
      add(0, 4'b0000, 4'b0000, 2'd0, 0);
      // reset clears the pointer
      add(1, 4'b0000, 4'b0000, 2'd0, 0);
      // drop and reassert: no priority carried over
      add(0, 4'b0011, 4'b0000, 2'd0, 0);
      add(0, 4'b0011, 4'b0001, 2'd0, 1);
      add(0, 4'b0011, 4'b0001, 2'd0, 1);
      add(0, 4'b0010, 4'b0001, 2'd0, 1);
      add(0, 4'b0010, 4'b0000, 2'd0, 0);
      add(0, 4'b0011, 4'b0010, 2'd1, 1);
      add(0, 4'b0001, 4'b0010, 2'd1, 1);
      add(0, 4'b0001, 4'b0000, 2'd0, 0);
      add(0, 4'b0001, 4'b0001, 2'd0, 1);
      add(0, 4'b0000, 4'b0001, 2'd0, 1);
      add(0, 4'b0000, 4'b0000, 2'd0, 0);
      // reset in the middle of turnaround; 1001 afterwards proves pointer=0
      add(0, 4'b0100, 4'b0000, 2'd0, 0);
      repeat (4) add(0, 4'b0100, 4'b0100, 2'd2, 1);
      add(0, 4'b0000, 4'b0100, 2'd2, 1);
      add(0, 4'b0001, 4'b0000, 2'd0, 1);
      add(1, 4'b0001, 4'b0000, 2'd0, 1);
      add(0, 4'b1001, 4'b0000, 2'd0, 0);
      add(0, 4'b0000, 4'b0001, 2'd0, 1);
      add(0, 4'b0000, 4'b0000, 2'd0, 0);

      rst = 1'b1;
      req = 4'b0000;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) begin
         chk_all("vec", i, vecs[i].g, vecs[i].s, vecs[i].b);
         rst = vecs[i].r;
         req = vecs[i].rq;
         @(negedge clk);
      end

      // long hold with a competing requester
      rst = 1'b1;
      req = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b1001;
      @(negedge clk);
`ifdef IO_PAD_ARBITER_TIMEOUT_EN
      for (int c = 1; c <= 4; c++) begin
         chk_all("hold", c, 4'b0001, 2'd0, 1);
         @(negedge clk);
      end
      chk_all("timeout_rel", 5, 4'b0000, 2'd0, 0);
      @(negedge clk);
      chk_all("timeout_next", 6, 4'b1000, 2'd3, 1);
`else
      for (int c = 1; c <= 100; c++) begin
         chk_all("hold", c, 4'b0001, 2'd0, 1);
         @(negedge clk);
      end
`endif
      req = 4'b0000;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
